// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks the enabled ADC channels, issues conversion
// requests to an LTC2308 core, optionally averages 2^AVG_LOG2 results per
// channel and publishes one 12-bit result slot per channel.
//
// Core handshake: measure_start is a one-cycle request for channel
// measure_ch; the core answers by raising measure_done (a level) with
// measured_data valid while it is high. Only the rising edge of
// measure_done counts as a completed conversion, and only while in WAIT.
module adc_scan_sequencer #(
  parameter int NUM_CH   = 6,
  parameter int AVG_LOG2 = 0,
  parameter int TIMEOUT  = 4095
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode_single,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 err_clr,
  output logic                 measure_start,
  output logic [2:0]           measure_ch,
  input  logic                 measure_done,
  input  logic [11:0]          measured_data,
  output logic [NUM_CH*12-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_valid,
  output logic                 sweep_done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [2:0]           state_dbg
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_STORE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_CH-1:0]  mask_q;
  logic               first_q;
  logic [2:0]         cur_ch;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   sample_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               done_q;

  logic               found;
  logic [2:0]         next_ch;
  logic               done_edge;
  logic               tmo_hit;
  logic               last_sample;
  logic               launch;

  assign done_edge   = measure_done & ~done_q;
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT));
  assign last_sample = ((sample_cnt + CNT_W'(1)) == N_SAMPLES);
  assign launch      = enable & (~mode_single | start);
  assign measure_ch  = cur_ch;

  // Lowest enabled channel above the current one (any channel on the first step).
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (first_q || (3'(i) > cur_ch))) begin
        found   = 1'b1;
        next_ch = 3'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a dropped enable is honoured only at conversion boundaries.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (launch) state_nxt = S_SELECT;
      S_SELECT: begin
        if (!enable)    state_nxt = S_IDLE;
        else if (found) state_nxt = S_START;
        else            state_nxt = S_IDLE;
      end
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_edge) begin
          if (!enable)         state_nxt = S_IDLE;
          else if (last_sample) state_nxt = S_STORE;
          else                 state_nxt = S_START;
        end else if (tmo_hit) begin
          state_nxt = enable ? S_SELECT : S_IDLE;
        end
      end
      S_STORE:  state_nxt = S_SELECT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Decoded outputs; all of them are inactive in IDLE.
  always_comb begin
    measure_start = (state == S_START);
    busy          = (state != S_IDLE);
    sweep_done    = (state == S_SELECT) && enable && !found;
    state_dbg     = state;
  end

  // Datapath: mask latch, channel pointer, accumulator, counters and result slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      first_q    <= 1'b0;
      cur_ch     <= '0;
      acc        <= '0;
      sample_cnt <= '0;
      tmo_cnt    <= '0;
      done_q     <= 1'b0;
      ch_data    <= '0;
      ch_valid   <= '0;
    end else begin
      done_q   <= measure_done;
      ch_valid <= '0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            mask_q  <= ch_mask;
            first_q <= 1'b1;
          end
        end
        S_SELECT: begin
          if (enable && found) begin
            cur_ch     <= next_ch;
            first_q    <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
          end
        end
        S_START: tmo_cnt <= '0;
        S_WAIT: begin
          if (done_edge) begin
            acc        <= acc + ACC_W'(measured_data);
            sample_cnt <= sample_cnt + CNT_W'(1);
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_STORE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch == 3'(i)) begin
              ch_data[i*12 +: 12] <= acc[AVG_LOG2 +: 12];
              ch_valid[i]         <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         timeout_err <= 1'b0;
    else if ((state == S_WAIT) && !done_edge && tmo_hit) timeout_err <= 1'b1;
    else if (err_clr)                                   timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed bench for adc_scan_sequencer. dut0 runs
// with AVG_LOG2=0, dut2 with AVG_LOG2=2; each has a small conversion model.
module tb_adc_scan_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, enable, enable2, mode_single, start, start2, err_clr;
  logic [5:0] ch_mask;

  logic        ms0, md0 = 1'b0, sd0, busy0, terr0;
  logic [2:0]  mch0, st0;
  logic [11:0] mdata0 = '0;
  logic [71:0] chd0;
  logic [5:0]  cv0;

  logic        ms2, md2 = 1'b0, sd2, busy2, terr2;
  logic [2:0]  mch2, st2;
  logic [11:0] mdata2 = '0;
  logic [71:0] chd2;
  logic [5:0]  cv2;

  adc_scan_sequencer #(.NUM_CH(6), .AVG_LOG2(0), .TIMEOUT(4095)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_single(mode_single),
    .start(start), .ch_mask(ch_mask), .err_clr(err_clr),
    .measure_start(ms0), .measure_ch(mch0), .measure_done(md0),
    .measured_data(mdata0), .ch_data(chd0), .ch_valid(cv0),
    .sweep_done(sd0), .busy(busy0), .timeout_err(terr0), .state_dbg(st0));

  adc_scan_sequencer #(.NUM_CH(6), .AVG_LOG2(2), .TIMEOUT(4095)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .mode_single(mode_single),
    .start(start2), .ch_mask(ch_mask), .err_clr(err_clr),
    .measure_start(ms2), .measure_ch(mch2), .measure_done(md2),
    .measured_data(mdata2), .ch_data(chd2), .ch_valid(cv2),
    .sweep_done(sd2), .busy(busy2), .timeout_err(terr2), .state_dbg(st2));

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [2:0] exp_q[$];
  int  data_base   = 100;
  int  lat0        = 2;
  bit  withhold_ch3 = 1'b0;
  int  done_cyc0   = 0;
  int  ms_cyc0     = 0;
  int  n_ms0 = 0, n_sd0 = 0, n_ms2 = 0, n_cv2 = 0, n_sd2 = 0;

  // ---------------- conversion models ----------------
  int         cnt0 = 0;
  logic [2:0] rch0 = '0;
  always begin
    @(posedge clk); #1;
    md0 = 1'b0;
    if (cnt0 > 0) begin
      cnt0--;
      if (cnt0 == 0) begin
        mdata0    = 12'(data_base + int'(rch0));
        md0       = 1'b1;
        done_cyc0 = cyc;
      end
    end
    if (rst_n && ms0) begin
      rch0    = mch0;
      ms_cyc0 = cyc;
      if (!(withhold_ch3 && mch0 == 3'd3)) cnt0 = lat0;
    end
  end

  int cnt2 = 0;
  int idx2 = 0;
  int avg_tab[4] = '{10, 11, 12, 14};
  always begin
    @(posedge clk); #1;
    md2 = 1'b0;
    if (cnt2 > 0) begin
      cnt2--;
      if (cnt2 == 0) begin
        mdata2 = 12'(avg_tab[idx2]);
        idx2   = (idx2 + 1) % 4;
        md2    = 1'b1;
      end
    end
    if (rst_n && ms2) cnt2 = 2;
  end

  // ---------------- monitors / scoreboard ----------------
  logic [2:0] e_mon;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ms0) begin
        n_ms0++;
        check("ms_ch_range", 72'(mch0 < 3'd6), 72'd1);
      end
      if (sd0) n_sd0++;
      for (int i = 0; i < 6; i++) begin
        if (cv0[i]) begin
          if (exp_q.size() == 0) begin
            check("valid_unexpected", 72'(cv0), 72'd0);
          end else begin
            e_mon = exp_q.pop_front();
            check("valid_ch", 72'(i), 72'(e_mon));
            check("valid_data", 72'(chd0[i*12 +: 12]), 72'(data_base + int'(e_mon)));
            check("valid_latency", 72'(cyc - done_cyc0), 72'd2);
          end
        end
      end
      if (ms2) begin
        n_ms2++;
        check("avg_ms_ch", 72'(mch2), 72'd2);
      end
      if (cv2 != 6'd0) begin
        n_cv2++;
        check("avg_valid_bits", 72'(cv2), 72'b000100);
      end
      if (sd2) n_sd2++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sweep0(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sd0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic push_mask(input logic [5:0] m);
    for (int c = 0; c < 6; c++) if (m[c]) exp_q.push_back(3'(c));
  endtask

  typedef struct {
    logic [5:0] mask;
    int         exp_starts;
  } vec_t;
  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int base_ms, base_sd, t0;

    vecs[0] = '{6'b100010, 2};
    vecs[1] = '{6'b000000, 0};
    vecs[2] = '{6'b000001, 1};
    vecs[3] = '{6'b111111, 6};
    vecs[4] = '{6'b101010, 3};
    vecs[5] = '{6'b100000, 1};

    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; mode_single = 1'b1;
    start = 1'b0; start2 = 1'b0; err_clr = 1'b0; ch_mask = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 72'(busy0), 0);
    check("rst_state", 72'(st0), 0);
    check("rst_ch_data", chd0, 0);
    check("rst_ms", 72'(ms0), 0);
    check("rst_terr", 72'(terr0), 0);
    check("rst_busy2", 72'(busy2), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single-mode sweeps over a table of masks
    enable = 1'b1;
    foreach (vecs[v]) begin
      ch_mask = vecs[v].mask;
      push_mask(vecs[v].mask);
      base_ms = n_ms0; base_sd = n_sd0;
      pulse_start();
      wait_sweep0(300, ok);
      check("tbl_sweep_seen", 72'(ok), 1);
      repeat (3) @(posedge clk); #1;
      check("tbl_starts", 72'(n_ms0 - base_ms), 72'(vecs[v].exp_starts));
      check("tbl_sweeps", 72'(n_sd0 - base_sd), 1);
      check("tbl_busy", 72'(busy0), 0);
      check("tbl_q_empty", 72'(exp_q.size()), 0);
      base_ms = n_ms0;
      repeat (20) @(posedge clk); #1;
      check("tbl_no_restart", 72'(n_ms0 - base_ms), 0);
    end

    // start while busy is ignored
    ch_mask = 6'b100010;
    push_mask(6'b100010);
    base_ms = n_ms0; base_sd = n_sd0;
    pulse_start();
    repeat (4) @(posedge clk); #1;
    check("busy_mid", 72'(busy0), 1);
    pulse_start();
    wait_sweep0(300, ok);
    check("busy_sweep_seen", 72'(ok), 1);
    repeat (20) @(posedge clk); #1;
    check("busy_starts", 72'(n_ms0 - base_ms), 2);
    check("busy_sweeps", 72'(n_sd0 - base_sd), 1);

    // continuous mode: two full sweeps, restart via IDLE
    enable = 1'b0;
    ch_mask = 6'b111111;
    mode_single = 1'b0;
    push_mask(6'b111111);
    push_mask(6'b111111);
    base_ms = n_ms0; base_sd = n_sd0;
    @(posedge clk); #1;
    enable = 1'b1;
    wait_sweep0(500, ok);
    check("cont_sweep1", 72'(ok), 1);
    @(posedge clk); #1;
    check("cont_idle_gap", 72'(st0), 0);
    @(posedge clk); #1;
    check("cont_restart", 72'(st0), 1);
    wait_sweep0(500, ok);
    check("cont_sweep2", 72'(ok), 1);
    @(negedge clk); #1;
    enable = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("cont_starts", 72'(n_ms0 - base_ms), 12);
    check("cont_sweeps", 72'(n_sd0 - base_sd), 2);
    check("cont_q_empty", 72'(exp_q.size()), 0);
    check("cont_busy", 72'(busy0), 0);

    // conversion timeout on ch3, scan continues at ch4
    mode_single = 1'b1;
    ch_mask = 6'b011000;
    data_base = 200;
    withhold_ch3 = 1'b1;
    exp_q.push_back(3'd4);
    enable = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (terr0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    t0 = cyc - ms_cyc0;
    check("tmo_seen", 72'(ok), 1);
    check("tmo_delay_in_range", 72'((t0 >= 4095) && (t0 <= 4100)), 1);
    wait_sweep0(100, ok);
    check("tmo_sweep_seen", 72'(ok), 1);
    repeat (3) @(posedge clk); #1;
    check("tmo_ch3_kept", 72'(chd0[36 +: 12]), 103);
    check("tmo_ch4_new", 72'(chd0[48 +: 12]), 204);
    check("tmo_sticky", 72'(terr0), 1);
    check("tmo_q_empty", 72'(exp_q.size()), 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_clr", 72'(terr0), 0);

    // clear held high while a new timeout fires: the set must win
    ch_mask = 6'b001000;
    err_clr = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (terr0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
    check("tmo2_set_wins", 72'(ok), 1);
    repeat (5) @(posedge clk); #1;
    check("tmo2_sticky", 72'(terr0), 1);
    wait_sweep0(100, ok);
    withhold_ch3 = 1'b0;
    data_base = 100;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // enable drops while ch2 converts: finish, discard, no sweep_done
    enable = 1'b0;
    ch_mask = 6'b111111;
    mode_single = 1'b0;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    base_ms = n_ms0; base_sd = n_sd0;
    @(posedge clk); #1;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ms0 && mch0 == 3'd2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    check("abort_ch2_started", 72'(ok), 1);
    repeat (20) @(posedge clk); #1;
    check("abort_starts", 72'(n_ms0 - base_ms), 3);
    check("abort_no_sweep", 72'(n_sd0 - base_sd), 0);
    check("abort_busy", 72'(busy0), 0);
    check("abort_q_empty", 72'(exp_q.size()), 0);
    mode_single = 1'b1;

    // reset during WAIT on ch2; stale done arrives after release
    ch_mask = 6'b000100;
    lat0 = 8;
    enable = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (st0 == 3'd3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst2_in_wait", 72'(ok), 1);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rst2_busy", 72'(busy0), 0);
    check("rst2_ch_data", chd0, 0);
    check("rst2_valid", 72'(cv0), 0);
    check("rst2_mch", 72'(mch0), 0);
    check("rst2_state", 72'(st0), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    base_sd = n_sd0;
    repeat (20) @(posedge clk); #1;
    check("rst2_no_sweep", 72'(n_sd0 - base_sd), 0);
    check("rst2_idle", 72'(busy0), 0);
    lat0 = 2;

    // averaging instance: 4 conversions on ch2, mean of 10,11,12,14 -> 11
    ch_mask = 6'b000100;
    enable2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sd2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("avg_sweep_seen", 72'(ok), 1);
    repeat (3) @(posedge clk); #1;
    check("avg_starts", 72'(n_ms2), 4);
    check("avg_valid_pulses", 72'(n_cv2), 1);
    check("avg_data", 72'(chd2[24 +: 12]), 11);
    check("avg_sweeps", 72'(n_sd2), 1);
    check("avg_busy", 72'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 6, number of scanned channels; legal range 1..8.
REQ-002 Parameter AVG_LOG2, default 0, log2 of conversions averaged per channel; legal range 0..4.
REQ-003 Parameter TIMEOUT, default 4095, maximum clk cycles to wait for a conversion result.
REQ-004 clk  in  1  single clock, max 40 MHz; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; high permits scanning.
REQ-007 mode_single  in  1  1 = one sweep per start pulse; 0 = continuous sweeps.
REQ-008 start  in  1  one-cycle pulse; launches a sweep in single mode.
REQ-009 ch_mask  in  NUM_CH  per-channel scan enable, bit i = channel i.
REQ-010 err_clr  in  1  one-cycle pulse; clears timeout_err.
REQ-011 measure_start  out  1  one-cycle conversion request to the LTC2308 core.
REQ-012 measure_ch  out  3  channel select to the LTC2308 core.
REQ-013 measure_done  in  1  conversion-complete level from the core.
REQ-014 measured_data  in  12  conversion result from the core.
REQ-015 ch_data  out  NUM_CH*12  packed averaged results, channel i at bits [12i+11:12i].
REQ-016 ch_valid  out  NUM_CH  one-cycle pulse, bit i when channel i's ch_data updates.
REQ-017 sweep_done  out  1  one-cycle pulse at end of each sweep.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 timeout_err  out  1  sticky conversion-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, SELECT, START, WAIT, STORE.
REQ-021 IDLE -> SELECT when enable=1 and (mode_single=0 or start=1); ch_mask latched on this transition and held for the sweep.
REQ-022 SELECT SHALL pick the lowest enabled channel above the previous one (first sweep step: lowest enabled overall), drive measure_ch, clear accumulator and sample count, go to START; no remaining channel -> pulse sweep_done, go to IDLE.
REQ-023 Latched mask all zero SHALL produce a sweep_done pulse with no measure_start.
REQ-024 START SHALL assert measure_start for exactly one cycle, clear timeout counter, go to WAIT; measure_ch SHALL stay constant from SELECT until the channel leaves STORE.
REQ-025 WAIT SHALL detect the rising edge of measure_done (registered previous value), add measured_data into a (12+AVG_LOG2)-bit accumulator, increment sample count.
REQ-026 After the edge: count < 2^AVG_LOG2 -> START; otherwise -> STORE.
REQ-027 STORE SHALL write accumulator >> AVG_LOG2 (truncating) into ch_data slot, pulse ch_valid bit for that channel in the same cycle, go to SELECT.
REQ-028 With AVG_LOG2=0, ch_data SHALL equal measured_data of the single conversion; ch_valid SHALL pulse 2 cycles after the done edge-detect cycle.
REQ-029 WAIT counter reaching TIMEOUT SHALL set timeout_err, discard the channel's accumulation (no ch_data/ch_valid update), go to SELECT.
REQ-030 Continuous mode with enable=1 SHALL restart the next sweep from IDLE on the cycle after sweep_done; start ignored.
REQ-031 start pulses while busy=1 SHALL be ignored.
REQ-032 enable falling mid-sweep SHALL let the outstanding conversion finish (done edge or timeout), discard it, return to IDLE without sweep_done.
REQ-033 err_clr simultaneous with a new timeout SHALL leave timeout_err set.
REQ-034 Channels >= NUM_CH SHALL never be selected; measure_ch upper bits zero when NUM_CH <= 4.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE and zero ch_data, ch_valid, sweep_done, busy, timeout_err, measure_start, measure_ch, accumulator and counters.
REQ-036 Reset mid-conversion SHALL not produce any ch_valid or sweep_done pulse after release; the first post-reset done edge from a stale conversion SHALL be ignored because FSM is in IDLE.

Verification
REQ-037 NUM_CH=6, AVG_LOG2=0, continuous, mask 6'b111111, model returns 100+ch -> ch_data slots 100..105, ch_valid bits pulse in order 0..5, sweep_done once per sweep.
REQ-038 AVG_LOG2=2, mask 6'b000100, model returns 10,11,12,14 on ch2 -> 4 measure_start pulses on ch2, ch_data[2]=11, one ch_valid[2] pulse.
REQ-039 Single mode, mask 6'b100010, start pulse -> conversions on ch1 then ch5 only, sweep_done, busy low, no further measure_start until next start.
REQ-040 Model withholds measure_done on ch3 -> timeout_err set after TIMEOUT cycles, ch_data[3] unchanged, scan continues at ch4; err_clr pulse -> timeout_err 0.
REQ-041 Mask 6'b000000 with start -> sweep_done pulse, zero measure_start pulses.
REQ-042 rst_n low during WAIT on ch2 -> all outputs zero immediately, no ch_valid after release.
